// File: rtl/apb_timer_multi_if.sv
// APB slave bus bundle for the multi-channel timer.
// The master drives address, control and write data; the slave returns read data and ready.
interface apb_timer_multi_if;
  logic [7:0]  apb_paddr_s;
  logic        apb_pwrite_s;
  logic        apb_psel_s;
  logic        apb_penable_s;
  logic [31:0] apb_pwdata_s;
  logic [31:0] apb_prdata_s;
  logic        apb_pready_s;

  modport master (
    output apb_paddr_s, apb_pwrite_s, apb_psel_s, apb_penable_s, apb_pwdata_s,
    input  apb_prdata_s, apb_pready_s
  );

  modport slave (
    input  apb_paddr_s, apb_pwrite_s, apb_psel_s, apb_penable_s, apb_pwdata_s,
    output apb_prdata_s, apb_pready_s
  );
endinterface

// File: rtl/apb_timer_multi.sv
// NUM_CH independent prescaled up-counters with compare match, one-shot mode,
// sticky W1C tick flags and maskable interrupts behind a zero-wait APB slave.
module apb_timer_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PSC_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  apb_timer_multi_if.slave  apb,
  output logic [NUM_CH-1:0] irq_o,
  output logic              irq_any_o
);

  logic              access_s;
  logic              wr_s;
  logic              rd_s;
  logic [3:0]        ch_idx_s;
  logic [1:0]        reg_idx_s;
  logic              irq_stat_hit_s;
  logic              irq_stat_wr_s;
  logic [31:0]       ch_rdata_s [NUM_CH];
  logic [NUM_CH-1:0] tick_s;
  logic [NUM_CH-1:0] irq_nxt_s;
  logic [NUM_CH-1:0] irq_r;
  logic              irq_any_r;
  logic [31:0]       rd_acc_s;
  logic [31:0]       prdata_s;
  logic              unused_s;

  // Bus phase and address decode
  always_comb begin
    access_s       = apb.apb_psel_s & apb.apb_penable_s;
    wr_s           = access_s & apb.apb_pwrite_s;
    rd_s           = access_s & ~apb.apb_pwrite_s;
    ch_idx_s       = apb.apb_paddr_s[7:4];
    reg_idx_s      = apb.apb_paddr_s[3:2];
    irq_stat_hit_s = (apb.apb_paddr_s[7:2] == 6'h3C);
    irq_stat_wr_s  = wr_s & irq_stat_hit_s;
  end

  assign unused_s = ^{apb.apb_paddr_s[1:0], apb.apb_pwdata_s};

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    localparam logic [3:0] CH_IDX = 4'(n);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cmp_r;
    logic [PSC_W-1:0] psc_r;
    logic [PSC_W-1:0] psc_cnt_r;
    logic             ena_r;
    logic             mode_r;
    logic             irq_en_r;
    logic             tick_r;
    logic             sel_s;
    logic             cmp_we_s;
    logic             cfg_we_s;
    logic             clr_s;
    logic             w1c_s;
    logic             step_s;
    logic             match_s;
    logic             hw_set_s;
    logic             tick_nxt_s;
    logic             irq_en_nxt_s;
    logic [31:0]      rd_word_s;

    // Write strobes plus step/match events; clr suppresses the step on its edge
    always_comb begin
      sel_s        = (ch_idx_s == CH_IDX);
      cmp_we_s     = wr_s & sel_s & (reg_idx_s == 2'd1);
      cfg_we_s     = wr_s & sel_s & (reg_idx_s == 2'd2);
      clr_s        = cfg_we_s & apb.apb_pwdata_s[1];
      w1c_s        = (wr_s & sel_s & (reg_idx_s == 2'd3) & apb.apb_pwdata_s[0])
                   | (irq_stat_wr_s & apb.apb_pwdata_s[n]);
      step_s       = ena_r & (psc_cnt_r == psc_r) & ~clr_s;
      match_s      = (cnt_r == cmp_r);
      hw_set_s     = step_s & match_s;
      tick_nxt_s   = hw_set_s | (tick_r & ~w1c_s);
      irq_en_nxt_s = cfg_we_s ? apb.apb_pwdata_s[3] : irq_en_r;
    end

    // Channel state; a software CFG write overrides the one-shot ena clear
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_r     <= {CNT_W{1'b0}};
        cmp_r     <= {CNT_W{1'b1}};
        psc_r     <= {PSC_W{1'b0}};
        psc_cnt_r <= {PSC_W{1'b0}};
        ena_r     <= 1'b0;
        mode_r    <= 1'b0;
        irq_en_r  <= 1'b0;
        tick_r    <= 1'b0;
      end else begin
        if (cmp_we_s) begin
          cmp_r <= apb.apb_pwdata_s[CNT_W-1:0];
        end
        if (cfg_we_s) begin
          ena_r    <= apb.apb_pwdata_s[0];
          mode_r   <= apb.apb_pwdata_s[2];
          irq_en_r <= apb.apb_pwdata_s[3];
          psc_r    <= apb.apb_pwdata_s[8 +: PSC_W];
        end else if (hw_set_s & mode_r) begin
          ena_r <= 1'b0;
        end
        if (clr_s) begin
          cnt_r     <= {CNT_W{1'b0}};
          psc_cnt_r <= {PSC_W{1'b0}};
        end else if (step_s) begin
          psc_cnt_r <= {PSC_W{1'b0}};
          cnt_r     <= match_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1'b1);
        end else if (ena_r) begin
          psc_cnt_r <= psc_cnt_r + PSC_W'(1'b1);
        end
        tick_r <= tick_nxt_s;
      end
    end

    // Per-channel read word for the selected register offset
    always_comb begin
      rd_word_s = 32'd0;
      case (reg_idx_s)
        2'd0: rd_word_s[CNT_W-1:0] = cnt_r;
        2'd1: rd_word_s[CNT_W-1:0] = cmp_r;
        2'd2: begin
          rd_word_s[0]          = ena_r;
          rd_word_s[2]          = mode_r;
          rd_word_s[3]          = irq_en_r;
          rd_word_s[8 +: PSC_W] = psc_r;
        end
        2'd3: rd_word_s[0] = tick_r;
        default: rd_word_s = 32'd0;
      endcase
    end

    assign ch_rdata_s[n] = sel_s ? rd_word_s : 32'd0;
    assign tick_s[n]     = tick_r;
    assign irq_nxt_s[n]  = tick_nxt_s & irq_en_nxt_s;
  end

  // Interrupt flops track the next tick/irq_en state so irq_o rises right after the match edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_r     <= {NUM_CH{1'b0}};
      irq_any_r <= 1'b0;
    end else begin
      irq_r     <= irq_nxt_s;
      irq_any_r <= |irq_nxt_s;
    end
  end

  // Read data mux; only one channel word can be non-zero at a time
  always_comb begin
    rd_acc_s = 32'd0;
    for (int n = 0; n < NUM_CH; n++) begin
      rd_acc_s = rd_acc_s | ch_rdata_s[n];
    end
    rd_acc_s = rd_acc_s | (irq_stat_hit_s ? 32'(tick_s) : 32'd0);
    prdata_s = rd_s ? rd_acc_s : 32'd0;
  end

  assign apb.apb_prdata_s = prdata_s;
  assign apb.apb_pready_s = access_s;
  assign irq_o            = irq_r;
  assign irq_any_o        = irq_any_r;

endmodule
